datapath: RTL

DATAPATH -- requirements
Module: datapath

---
 rtl/cpu_pkg.sv | 56 +++++
 rtl/alu.sv | 27 ++
 rtl/datapath.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the control unit and datapath of the 8-bit CPU:
// data width, opcode encodings, control-word bit positions and small helpers.
package cpu_pkg;

    localparam int DATA_W   = 8;
    localparam int OPCODE_W = 4;
    localparam int NUM_DRV  = 5;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    // Bit positions of each strobe inside the control word.
    localparam int CW_HLT    = 0;
    localparam int CW_PC_INC = 1;
    localparam int CW_PC_JMP = 2;
    localparam int CW_PC_OUT = 3;
    localparam int CW_A_RD   = 4;
    localparam int CW_A_WR   = 5;
    localparam int CW_B_RD   = 6;
    localparam int CW_B_WR   = 7;
    localparam int CW_I_RD   = 8;
    localparam int CW_I_WR   = 9;
    localparam int CW_MAR_RD = 10;
    localparam int CW_RAM_RD = 11;
    localparam int CW_RAM_WR = 12;
    localparam int CW_ALU_OUT = 13;
    localparam int CW_ALU_SUB = 14;
    localparam int CW_ALU_FI = 15;
    localparam int CW_OUT_EN = 16;
    localparam int CW_W      = 17;

    function automatic logic [2:0] bus_driver_count(input logic [NUM_DRV-1:0] drv);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int k = 0; k < NUM_DRV; k++) begin
            cnt = cnt + {2'b00, drv[k]};
        end
        return cnt;
    endfunction

    function automatic logic even_parity(input logic [DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 8-bit adder/subtractor; subtraction is A + ~B + 1 so carry
// means "no borrow". Flag registers live in the datapath.
module alu
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              subtract,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W-1:0] w_b_op;
    logic [DATA_W:0]   w_sum;

    // Operand conditioning and 9-bit sum including the subtract carry-in.
    always_comb begin
        w_b_op = subtract ? ~b : b;
        w_sum  = {1'b0, a} + {1'b0, w_b_op} + {{DATA_W{1'b0}}, subtract};
    end

    assign result = w_sum[DATA_W-1:0];
    assign carry  = w_sum[DATA_W];
    assign zero   = (w_sum[DATA_W-1:0] == {DATA_W{1'b0}});

endmodule

// File: rtl/datapath.sv
// Datapath of the 8-bit bus CPU: registers, RAM, PC, ALU flags and output.
// Define DATAPATH_BUS_CHECK_EN to add the sticky bus_conflict output.
module datapath
    import cpu_pkg::*;
#(
    parameter int RAM_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_halt,
    input  logic                  pc_inc,
    input  logic                  pc_jump,
    input  logic                  pc_out,
    input  logic                  a_reg_read_from_bus,
    input  logic                  a_reg_write_to_bus,
    input  logic                  b_reg_read_from_bus,
    input  logic                  b_reg_write_to_bus,
    input  logic                  i_reg_read_from_bus,
    input  logic                  i_reg_write_to_bus,
    input  logic                  mar_read_from_bus,
    input  logic                  ram_read_from_bus,
    input  logic                  ram_write_to_bus,
    input  logic                  alu_out,
    input  logic                  alu_subtract,
    input  logic                  alu_flags_in,
    input  logic                  out_en,
    input  logic                  prog_we,
    input  logic [RAM_ADDR_W-1:0] prog_addr,
    input  logic [7:0]            prog_data,
    output logic [3:0]            instruction,
    output logic                  alu_carry,
    output logic                  alu_zero,
    output logic [7:0]            out_value,
    output logic                  out_valid,
    output logic                  halted
`ifdef DATAPATH_BUS_CHECK_EN
    ,
    output logic                  bus_conflict
`endif
);

    localparam int RAM_DEPTH = 2 ** RAM_ADDR_W;

    logic [DATA_W-1:0]     r_a;
    logic [DATA_W-1:0]     r_b;
    logic [DATA_W-1:0]     r_i;
    logic [RAM_ADDR_W-1:0] r_mar;
    logic [RAM_ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0]     r_ram [RAM_DEPTH];
    logic                  r_carry;
    logic                  r_zero;
    logic [DATA_W-1:0]     r_out_value;
    logic                  r_out_valid;
    logic                  r_halted;

    logic [CW_W-1:0]       w_cw;
    logic [NUM_DRV-1:0]    w_drv;
    logic [DATA_W-1:0]     w_bus;
    logic [DATA_W-1:0]     w_ram_rd;
    logic [DATA_W-1:0]     w_alu_result;
    logic                  w_alu_carry;
    logic                  w_alu_zero;
    logic                  w_prog_ok;

    assign w_cw[CW_HLT]     = clk_halt;
    assign w_cw[CW_PC_INC]  = pc_inc;
    assign w_cw[CW_PC_JMP]  = pc_jump;
    assign w_cw[CW_PC_OUT]  = pc_out;
    assign w_cw[CW_A_RD]    = a_reg_read_from_bus;
    assign w_cw[CW_A_WR]    = a_reg_write_to_bus;
    assign w_cw[CW_B_RD]    = b_reg_read_from_bus;
    assign w_cw[CW_B_WR]    = b_reg_write_to_bus;
    assign w_cw[CW_I_RD]    = i_reg_read_from_bus;
    assign w_cw[CW_I_WR]    = i_reg_write_to_bus;
    assign w_cw[CW_MAR_RD]  = mar_read_from_bus;
    assign w_cw[CW_RAM_RD]  = ram_read_from_bus;
    assign w_cw[CW_RAM_WR]  = ram_write_to_bus;
    assign w_cw[CW_ALU_OUT] = alu_out;
    assign w_cw[CW_ALU_SUB] = alu_subtract;
    assign w_cw[CW_ALU_FI]  = alu_flags_in;
    assign w_cw[CW_OUT_EN]  = out_en;

    // b_reg_write_to_bus is accepted but B is not a bus source.
    assign w_drv = {w_cw[CW_ALU_OUT], w_cw[CW_RAM_WR], w_cw[CW_PC_OUT],
                    w_cw[CW_I_WR], w_cw[CW_A_WR]};

    assign w_ram_rd  = r_ram[r_mar];
    assign w_prog_ok = rst | r_halted;

    alu u_alu (
        .a        (r_a),
        .b        (r_b),
        .subtract (w_cw[CW_ALU_SUB]),
        .result   (w_alu_result),
        .carry    (w_alu_carry),
        .zero     (w_alu_zero)
    );

    // Wired-OR bus: every enabled driver contributes, idle bus reads as zero.
    always_comb begin
        w_bus = ({DATA_W{w_drv[0]}} & r_a)
              | ({DATA_W{w_drv[1]}} & {4'h0, r_i[3:0]})
              | ({DATA_W{w_drv[2]}} & {{(DATA_W-RAM_ADDR_W){1'b0}}, r_pc})
              | ({DATA_W{w_drv[3]}} & w_ram_rd)
              | ({DATA_W{w_drv[4]}} & w_alu_result);
    end

    // Architectural registers; all strobes are frozen once halted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a         <= {DATA_W{1'b0}};
            r_b         <= {DATA_W{1'b0}};
            r_i         <= {DATA_W{1'b0}};
            r_mar       <= {RAM_ADDR_W{1'b0}};
            r_pc        <= {RAM_ADDR_W{1'b0}};
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_out_value <= {DATA_W{1'b0}};
            r_out_valid <= 1'b0;
            r_halted    <= 1'b0;
        end else if (!r_halted) begin
            if (w_cw[CW_A_RD]) begin
                r_a <= w_bus;
            end
            if (w_cw[CW_B_RD]) begin
                r_b <= w_bus;
            end
            if (w_cw[CW_I_RD]) begin
                r_i <= w_bus;
            end
            if (w_cw[CW_MAR_RD]) begin
                r_mar <= w_bus[RAM_ADDR_W-1:0];
            end
            if (w_cw[CW_PC_JMP]) begin
                r_pc <= w_bus[RAM_ADDR_W-1:0];
            end else if (w_cw[CW_PC_INC]) begin
                r_pc <= r_pc + {{(RAM_ADDR_W-1){1'b0}}, 1'b1};
            end
            if (w_cw[CW_ALU_FI]) begin
                r_carry <= w_alu_carry;
                r_zero  <= w_alu_zero;
            end
            if (w_cw[CW_OUT_EN]) begin
                r_out_value <= w_bus;
            end
            r_out_valid <= w_cw[CW_OUT_EN];
            r_halted    <= w_cw[CW_HLT];
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    // RAM: program port only while stopped, bus store only while running.
    always_ff @(posedge clk) begin
        if (w_prog_ok && prog_we) begin
            r_ram[prog_addr] <= prog_data;
        end else if (!w_prog_ok && w_cw[CW_RAM_RD]) begin
            r_ram[r_mar] <= w_bus;
        end
    end

`ifdef DATAPATH_BUS_CHECK_EN
    logic r_bus_conflict;
    logic w_multi_drv;

    assign w_multi_drv = (bus_driver_count(w_drv) >= 3'd2);

    // Sticky record of any cycle with two or more bus drivers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_conflict <= 1'b0;
        end else if (w_multi_drv) begin
            r_bus_conflict <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    // Simulation-only report of each contended cycle.
    always_ff @(posedge clk) begin
        if (!rst && w_multi_drv) begin
            $error("datapath: %0d drivers on bus", bus_driver_count(w_drv));
        end
    end
`endif

    assign bus_conflict = r_bus_conflict;
`endif

    assign instruction = r_i[7:4];
    assign alu_carry   = r_carry;
    assign alu_zero    = r_zero;
    assign out_value   = r_out_value;
    assign out_valid   = r_out_valid;
    assign halted      = r_halted;

endmodule
